// File: rtl/counter_seq_ctrl.sv
// Opcode sequencer for the counter datapath: cmd_ready is combinational (low in STEP/LOADING or when ena=0),
// done is registered one cycle after a limit match. Define COUNTER_SEQ_AUTORELOAD_EN to reload and keep running on a match.
module counter_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ena,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_arg,
    input  logic [WIDTH-1:0] cnt_value,
    output logic             cnt_en,
    output logic             cnt_up,
    output logic             cnt_load,
    output logic [WIDTH-1:0] cnt_load_val,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_STEP    = 2'd2,
        S_LOADING = 2'd3
    } state_t;

    localparam logic [2:0] OP_NOP          = 3'd0;
    localparam logic [2:0] OP_LOAD         = 3'd1;
    localparam logic [2:0] OP_SET_LIMIT    = 3'd2;
    localparam logic [2:0] OP_RUN_UP       = 3'd3;
    localparam logic [2:0] OP_RUN_DOWN     = 3'd4;
    localparam logic [2:0] OP_STOP         = 3'd5;
    localparam logic [2:0] OP_STEP         = 3'd6;
    localparam logic [2:0] OP_SET_PRESCALE = 3'd7;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit, psc, presc, reload;
    logic             dir, done_r;
    logic             cmd_fire, is_idle, at_limit, tick, match, hit, stop_cmd, reload_cyc;

    assign cmd_ready = ena & (state_q == S_IDLE || state_q == S_RUN);
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign is_idle   = (state_q == S_IDLE);
    assign at_limit  = (cnt_value == limit);
    assign tick      = (presc == psc);
    assign stop_cmd  = cmd_fire & (cmd_op == OP_STOP);

`ifdef COUNTER_SEQ_AUTORELOAD_EN
    // The reload cycle still sees the old value at the limit, so it must not re-match.
    assign reload_cyc = (state_q == S_RUN) & done_r;
    assign match      = (state_q == S_RUN) & at_limit & ~done_r;
`else
    assign reload_cyc = 1'b0;
    assign match      = (state_q == S_RUN) & at_limit;
`endif
    assign hit = match & ~stop_cmd;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (ena) begin
            unique case (state_q)
                S_IDLE: begin
                    if (cmd_fire) begin
                        case (cmd_op)
                            OP_LOAD:                state_d = S_LOADING;
                            OP_RUN_UP, OP_RUN_DOWN: state_d = S_RUN;
                            OP_STEP:                state_d = S_STEP;
                            default:                state_d = S_IDLE;
                        endcase
                    end
                end
                S_RUN: begin
                    if (stop_cmd) state_d = S_IDLE;
`ifndef COUNTER_SEQ_AUTORELOAD_EN
                    else if (match) state_d = S_IDLE;
`endif
                end
                S_STEP:    state_d = S_IDLE;
                S_LOADING: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            limit  <= '1;
            psc    <= '0;
            presc  <= '0;
            reload <= '0;
            dir    <= 1'b1;
            done_r <= 1'b0;
        end else if (ena) begin
            done_r <= hit;
            if (cmd_fire) begin
                case (cmd_op)
                    OP_NOP:          ;
                    OP_SET_LIMIT:    limit <= cmd_arg;
                    OP_SET_PRESCALE: psc   <= cmd_arg;
                    OP_LOAD:         if (is_idle) reload <= cmd_arg;
                    OP_RUN_UP:       if (is_idle) dir <= 1'b1;
                    OP_RUN_DOWN:     if (is_idle) dir <= 1'b0;
                    OP_STEP:         if (is_idle) dir <= cmd_arg[0];
                    default:         ;
                endcase
            end
            // Held at zero outside RUN so entering RUN always starts a fresh prescale period.
            if (state_q != S_RUN || match || reload_cyc || tick) presc <= '0;
            else                                                 presc <= presc + 1'b1;
        end
    end

    always_comb begin
        cnt_en   = 1'b0;
        cnt_load = 1'b0;
        if (ena) begin
            unique case (state_q)
                S_RUN: begin
                    cnt_en   = tick & ~at_limit & ~reload_cyc;
                    cnt_load = reload_cyc;
                end
                S_STEP:    cnt_en   = 1'b1;
                S_LOADING: cnt_load = 1'b1;
                S_IDLE:    ;
            endcase
        end
    end

    assign done         = ena & done_r;
    assign busy         = (state_q != S_IDLE);
    assign cnt_up       = dir;
    assign cnt_load_val = reload;
    assign state        = state_q;

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Directed bench for counter_seq_ctrl with a behavioural 8-bit counter closing the loop.
module tb_counter_seq_ctrl;

    logic       clk, rst, ena, cmd_valid, cmd_ready;
    logic [2:0] cmd_op;
    logic [7:0] cmd_arg, cnt_load_val;
    logic       cnt_en, cnt_up, cnt_load, busy, done;
    logic [1:0] state;
    logic [7:0] cnt;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    counter_seq_ctrl #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
        .cnt_value(cnt), .cnt_en(cnt_en), .cnt_up(cnt_up), .cnt_load(cnt_load),
        .cnt_load_val(cnt_load_val), .busy(busy), .done(done), .state(state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)           cnt <= 8'd0;
        else if (cnt_load) cnt <= cnt_load_val;
        else if (cnt_en)   cnt <= cnt_up ? cnt + 8'd1 : cnt - 8'd1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic send(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; ena = 1'b1; cmd_valid = 1'b0; cmd_op = 3'd0; cmd_arg = 8'd0;
        cyc(); cyc();
        settle();
        chk("rst_state", state, 0);
        chk("rst_ready", cmd_ready, 1);
        chk("rst_up", cnt_up, 1);
        chk("rst_en", cnt_en, 0);
        chk("rst_load", cnt_load, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_loadval", cnt_load_val, 0);
        chk("rst_limit", dut.limit, 8'hFF);
        ena = 1'b0; #1;
        chk("rst_ready_ena0", cmd_ready, 0);
        ena = 1'b1;
        cyc();
        rst = 1'b0;
        cyc();

        // LOAD 0x10 then STEP up
        send(3'd1, 8'h10);
        settle();
        chk("load_state", state, 3);
        chk("load_pulse", cnt_load, 1);
        chk("load_val", cnt_load_val, 8'h10);
        chk("load_ready", cmd_ready, 0);
        chk("load_busy", busy, 1);
        cyc(); settle();
        chk("load_cnt", cnt, 8'h10);
        chk("load_idle", state, 0);
        chk("load_ready_back", cmd_ready, 1);
        chk("load_pulse_off", cnt_load, 0);
        send(3'd6, 8'h01);
        settle();
        chk("step_state", state, 2);
        chk("step_en", cnt_en, 1);
        chk("step_up", cnt_up, 1);
        cyc(); settle();
        chk("step_cnt", cnt, 8'h11);
        chk("step_idle", state, 0);
        chk("step_done", done, 0);
        chk("step_en_off", cnt_en, 0);

        // limit 5, prescale 2, run up from 0
        send(3'd1, 8'h00); cyc();
        send(3'd2, 8'd5);
        send(3'd7, 8'd2);
        send(3'd3, 8'd0);
        for (int i = 0; i < 16; i++) begin
            settle();
            chk($sformatf("run_en[%0d]", i), cnt_en,
                (i == 2 || i == 5 || i == 8 || i == 11 || i == 14) ? 1 : 0);
            chk($sformatf("run_done[%0d]", i), done, 0);
            if (i == 1) chk("run_ready", cmd_ready, 1);
            cyc();
        end
        settle();
        chk("run_done_pulse", done, 1);
        chk("run_cnt_limit", cnt, 5);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        chk("run_reload_state", state, 1);
        chk("run_reload_load", cnt_load, 1);
        send(3'd5, 8'd0);
`else
        chk("run_done_state", state, 0);
        chk("run_load_off", cnt_load, 0);
        cyc();
`endif
        settle();
        chk("run_done_end", done, 0);

        // RUN entered already at the limit
        send(3'd7, 8'd0);
        send(3'd1, 8'd9); cyc();
        send(3'd2, 8'd9);
        send(3'd4, 8'd0);
        settle();
        chk("atlim_state", state, 1);
        chk("atlim_en", cnt_en, 0);
        chk("atlim_done0", done, 0);
        chk("atlim_dir", cnt_up, 0);
        cyc(); settle();
        chk("atlim_done1", done, 1);
        chk("atlim_cnt", cnt, 9);
`ifdef COUNTER_SEQ_AUTORELOAD_EN
        send(3'd5, 8'd0);
`else
        chk("atlim_idle", state, 0);
        cyc();
`endif
        settle();
        chk("atlim_done2", done, 0);
        chk("atlim_end_state", state, 0);

        // STOP coinciding with a limit match
        send(3'd2, 8'd3);
        send(3'd1, 8'd0); cyc();
        send(3'd3, 8'd0);
        settle();
        chk("stop_en0", cnt_en, 1);
        cyc(); cyc(); cyc(); settle();
        chk("stop_cnt", cnt, 3);
        chk("stop_en_at_lim", cnt_en, 0);
        chk("stop_ready", cmd_ready, 1);
        send(3'd5, 8'd0);
        settle();
        chk("stop_state", state, 0);
        chk("stop_done0", done, 0);
        cyc(); settle();
        chk("stop_done1", done, 0);
        chk("stop_cnt_hold", cnt, 3);

        // freeze for 4 cycles during RUN
        send(3'd2, 8'd20);
        send(3'd1, 8'd0); cyc();
        send(3'd7, 8'd2);
        send(3'd3, 8'd0);
        cyc(); cyc(); cyc(); cyc();
        ena = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            chk($sformatf("frz_en[%0d]", k), cnt_en, 0);
            chk($sformatf("frz_ready[%0d]", k), cmd_ready, 0);
            chk($sformatf("frz_presc[%0d]", k), dut.presc, 1);
            chk($sformatf("frz_cnt[%0d]", k), cnt, 1);
            cyc();
        end
        ena = 1'b1;
        settle();
        chk("frz_resume_en0", cnt_en, 0);
        chk("frz_resume_presc", dut.presc, 1);
        cyc(); settle();
        chk("frz_resume_en1", cnt_en, 1);
        cyc(); settle();
        chk("frz_resume_cnt", cnt, 2);
        send(3'd5, 8'd0);

        // LOADING deferred while ena is low
        send(3'd1, 8'h42);
        ena = 1'b0;
        settle();
        chk("defer_load0", cnt_load, 0);
        chk("defer_state0", state, 3);
        cyc(); settle();
        chk("defer_state1", state, 3);
        chk("defer_cnt", cnt, 2);
        cyc();
        ena = 1'b1;
        settle();
        chk("defer_load1", cnt_load, 1);
        cyc(); settle();
        chk("defer_cnt_loaded", cnt, 8'h42);
        chk("defer_idle", state, 0);

        // asynchronous reset mid-run
        send(3'd2, 8'd100);
        send(3'd4, 8'd0);
        cyc(); cyc();
        rst = 1'b1;
        #1;
        chk("arst_state", state, 0);
        chk("arst_busy", busy, 0);
        chk("arst_up", cnt_up, 1);
        chk("arst_limit", dut.limit, 8'hFF);
        chk("arst_en", cnt_en, 0);
        cyc();
        rst = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
